div_issue_ctrl: RTL and testbench

//  Execute-stage sequencer that sits directly upstream of the div unit: accepts one
//  div/mod op per transaction from issue (valid/ready), pulses it into div exactly once,

---
 rtl/div_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage sequencer in front of the div unit.
// It accepts one div/mod op from issue and launches it into div with a single pulse.
// It then waits for div_ok and holds the result until writeback takes it.
// A flush while an op is in flight drains the outstanding result and discards it.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero divisor is
// resolved locally and div is never launched for that op.

package div_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_MOD  = 2'd2,
        DIV_MODU = 2'd3
    } div_opcode_t;
endpackage

module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  div_opcode_t      in_opcode,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_valid,
    output div_opcode_t      div_opcode,
    output logic [31:0]      div_src1,
    output logic [31:0]      div_src2,
    input  logic             div_ok,
    input  logic [31:0]      div_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, DONE} state_t;

    localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    state_t           state;
    logic             div_valid_q;
    logic [TAG_W-1:0] op_tag;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;

`ifdef DIV_ZERO_BYPASS_EN
    logic        bypass;
    logic [31:0] bypass_result;

    // Divide-by-zero answer: all ones for a quotient, the dividend for a remainder
    assign bypass        = (in_src2 == '0);
    assign bypass_result = (in_opcode == DIV_DIV || in_opcode == DIV_DIVU) ? '1 : in_src1;
`endif

    // Handshake decode; flush blocks acceptance in every state
    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign div_valid = div_valid_q && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Main sequencer: op capture, launch pulse, result capture and flush handling
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            div_valid_q <= 1'b0;
            div_opcode  <= DIV_DIV;
            div_src1    <= '0;
            div_src2    <= '0;
            op_tag      <= '0;
            out_result  <= '0;
            out_tag     <= '0;
        end else begin
            div_valid_q <= 1'b0;
            if (accept) begin
                div_opcode <= in_opcode;
                div_src1   <= in_src1;
                div_src2   <= in_src2;
                op_tag     <= in_tag;
            end
            case (state)
                // IDLE and DONE share the accept path so back-to-back issue needs no bubble
                IDLE, DONE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (accept) begin
`ifdef DIV_ZERO_BYPASS_EN
                        if (bypass) begin
                            state      <= DONE;
                            out_result <= bypass_result;
                            out_tag    <= in_tag;
                        end else
`endif
                        begin
                            state       <= LAUNCH;
                            div_valid_q <= 1'b1;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    state <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state <= div_ok ? IDLE : DRAIN;
                    end else if (div_ok) begin
                        out_result <= div_result;
                        out_tag    <= op_tag;
                        state      <= DONE;
                    end
                end
                DRAIN: begin
                    if (div_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Wait watchdog: counts WAIT/DRAIN cycles, saturates, raises a sticky error at MAX_WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == LAUNCH && !flush) begin
            wait_cnt <= '0;
        end else if ((state == WAIT || state == DRAIN) && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_MAX - 1'b1) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl; the bench plays the div unit.
module tb_div_issue_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    div_opcode_t in_opcode = DIV_DIV;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic [4:0]  in_tag = '0;
    logic        div_valid;
    div_opcode_t div_opcode;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_ok = 1'b0;
    logic [31:0] div_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int p0;

    div_issue_ctrl #(.TAG_W(5), .MAX_WAIT(64)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .div_valid(div_valid), .div_opcode(div_opcode), .div_src1(div_src1), .div_src2(div_src2),
        .div_ok(div_ok), .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Launch pulses seen by the div unit, sampled mid-cycle
    always @(negedge clk) if (div_valid === 1'b1) pulse_cnt++;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input div_opcode_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid  = 1'b1;
        in_opcode = op;
        in_src1   = a;
        in_src2   = b;
        in_tag    = tag;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (div_valid !== 1'b0) begin errors++; $display("FAIL reset_div_valid: got %b expected 0", div_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        checks++; if (div_src1 !== 32'h0 || div_src2 !== 32'h0) begin errors++; $display("FAIL reset_div_src: got %h/%h expected 0/0", div_src1, div_src2); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        p0 = pulse_cnt;
        offer(DIV_DIV, 32'd100, 32'hFFFF_FFF9, 5'd3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (div_valid !== 1'b1) begin errors++; $display("FAIL basic_launch: got %b expected 1", div_valid); end
        checks++; if (div_opcode !== DIV_DIV || div_src1 !== 32'd100 || div_src2 !== 32'hFFFF_FFF9) begin
            errors++; $display("FAIL basic_operands: got %0d %h %h expected 0 00000064 fffffff9", div_opcode, div_src1, div_src2); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (div_valid !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL basic_wait_%0d: got div_valid=%b out_valid=%b expected 0/0", i, div_valid, out_valid); end
        end
        tick();
        div_ok = 1'b1;
        div_result = 32'hFFFF_FFF2;
        tick();
        div_ok = 1'b0;
        div_result = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFF2 || out_tag !== 5'd3) begin
                errors++; $display("FAIL basic_hold_%0d: got %b %h %0d expected 1 fffffff2 3", i, out_valid, out_result, out_tag); end
            if (i < 3) tick();
        end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d expected 1", pulse_cnt - p0); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_done_in_ready: got %b expected 1", in_ready); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b/%b expected 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        p0 = pulse_cnt;
        offer(DIV_DIVU, 32'd50, 32'd5, 5'd1);
        tick();
        in_valid = 1'b0;
        tick();
        div_ok = 1'b1;
        div_result = 32'd10;
        tick();
        div_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd10 || out_tag !== 5'd1) begin
            errors++; $display("FAIL b2b_first: got %b %0d %0d expected 1 10 1", out_valid, out_result, out_tag); end
        out_ready = 1'b1;
        offer(DIV_MODU, 32'd50, 32'd7, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (div_valid !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second_launch: got div_valid=%b out_valid=%b expected 1/0", div_valid, out_valid); end
        checks++; if (div_opcode !== DIV_MODU || div_src1 !== 32'd50 || div_src2 !== 32'd7) begin
            errors++; $display("FAIL b2b_operands: got %0d %0d %0d expected 3 50 7", div_opcode, div_src1, div_src2); end
        tick();
        div_ok = 1'b1;
        div_result = 32'd1;
        tick();
        div_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_tag !== 5'd2) begin
            errors++; $display("FAIL b2b_second: got %b %0d %0d expected 1 1 2", out_valid, out_result, out_tag); end
        checks++; if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulse_cnt - p0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush_drain;
        offer(DIV_DIV, 32'd77, 32'd3, 5'd4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        offer(DIV_DIVU, 32'd9, 32'd9, 5'd5);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL drain_hold_%0d: got in_ready=%b busy=%b out_valid=%b expected 0/1/0", i, in_ready, busy, out_valid); end
            tick();
        end
        in_valid = 1'b0;
        div_ok = 1'b1;
        div_result = 32'h1111_2222;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_ok_in_ready: got %b expected 0", in_ready); end
        tick();
        div_ok = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || div_valid !== 1'b0) begin errors++; $display("FAIL drain_no_output: got %b/%b expected 0/0", out_valid, div_valid); end
    endtask

    task automatic test_flush_edges;
        p0 = pulse_cnt;
        offer(DIV_MOD, 32'd20, 32'd6, 5'd6);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        checks++; if (div_valid !== 1'b0) begin errors++; $display("FAIL flush_launch_div_valid: got %b expected 0", div_valid); end
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || pulse_cnt - p0 !== 0) begin
            errors++; $display("FAIL flush_launch_idle: got busy=%b pulses=%0d expected 0/0", busy, pulse_cnt - p0); end
        offer(DIV_MOD, 32'd20, 32'd6, 5'd6);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        div_ok = 1'b1;
        div_result = 32'd2;
        tick();
        flush = 1'b0;
        div_ok = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_ok_idle: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
        div_ok = 1'b1;
        tick();
        div_ok = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_ok_ignored: got busy=%b out_valid=%b expected 0/0", busy, out_valid); end
    endtask

    task automatic test_zero_divisor;
        p0 = pulse_cnt;
`ifdef DIV_ZERO_BYPASS_EN
        offer(DIV_MODU, 32'h0000_1234, 32'h0, 5'd7);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_1234 || out_tag !== 5'd7) begin
            errors++; $display("FAIL bypass_mod: got %b %h %0d expected 1 00001234 7", out_valid, out_result, out_tag); end
        out_ready = 1'b1;
        offer(DIV_DIVU, 32'd5, 32'h0, 5'd8);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_tag !== 5'd8) begin
            errors++; $display("FAIL bypass_div: got %b %h %0d expected 1 ffffffff 8", out_valid, out_result, out_tag); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL bypass_no_launch: got %0d expected 0", pulse_cnt - p0); end
`else
        offer(DIV_DIVU, 32'd5, 32'h0, 5'd8);
        tick();
        in_valid = 1'b0;
        checks++; if (div_valid !== 1'b1 || div_src2 !== 32'h0) begin
            errors++; $display("FAIL zero_launch: got %b %h expected 1 00000000", div_valid, div_src2); end
        tick();
        div_ok = 1'b1;
        div_result = 32'hFFFF_FFFF;
        tick();
        div_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_tag !== 5'd8) begin
            errors++; $display("FAIL zero_result: got %b %h %0d expected 1 ffffffff 8", out_valid, out_result, out_tag); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout;
        offer(DIV_DIV, 32'd1000, 32'd10, 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
        repeat (63) tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_at_max: got %b expected 1", timeout_err); end
        repeat (5) tick();
        div_ok = 1'b1;
        div_result = 32'd100;
        tick();
        div_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd100 || out_tag !== 5'd9 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_deliver: got %b %0d %0d %b expected 1 100 9 1", out_valid, out_result, out_tag, timeout_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky: got %b busy=%b expected 1/0", timeout_err, busy); end
    endtask

    task automatic test_reset_mid_wait;
        offer(DIV_MOD, 32'd33, 32'd4, 5'd10);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || div_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: got busy=%b out_valid=%b div_valid=%b timeout=%b expected 0/0/0/0", busy, out_valid, div_valid, timeout_err); end
        checks++; if (out_result !== 32'h0 || out_tag !== 5'h0 || div_src1 !== 32'h0 || div_src2 !== 32'h0) begin
            errors++; $display("FAIL rst_mid_data: got %h %h %h %h expected all 0", out_result, out_tag, div_src1, div_src2); end
        #1;
        resetn = 1'b1;
        tick();
        div_ok = 1'b1;
        div_result = 32'hDEAD_BEEF;
        tick();
        div_ok = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
            errors++; $display("FAIL rst_late_ok: got %b %b %h expected 0 0 00000000", out_valid, busy, out_result); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush_drain();
        test_flush_edges();
        test_zero_divisor();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
